// File: rtl/vxe_axi_switch_us_pkg.sv
// Shared constants and types for the AXI switch upstream unit.
// Request/write-data field positions, BIU channel widths and FSM state encodings.
package vxe_axi_switch_us_pkg;

  localparam int unsigned RQA_W        = 44;
  localparam int unsigned RQA_RNW      = 43;
  localparam int unsigned RQA_TXN_HI   = 42;
  localparam int unsigned RQA_TXN_LO   = 37;
  localparam int unsigned RQA_WADDR_HI = 36;
  localparam int unsigned RQA_WADDR_LO = 0;

  localparam int unsigned RQD_W       = 72;
  localparam int unsigned RQD_BEN_HI  = 71;
  localparam int unsigned RQD_BEN_LO  = 64;
  localparam int unsigned RQD_DATA_HI = 63;
  localparam int unsigned RQD_DATA_LO = 0;

  localparam int unsigned CID_W  = 6;
  localparam int unsigned ADDR_W = 40;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_RD = 2'd1,
    ST_BUSY_WR = 2'd2
  } us_state_t;

  // 64-bit word address to BIU byte address
  function automatic logic [ADDR_W-1:0] word_to_byte(
    input logic [RQA_WADDR_HI-RQA_WADDR_LO:0] waddr
  );
    return {waddr, 3'b000};
  endfunction

endpackage

// File: rtl/vxe_axi_switch_us_otcnt.sv
// Outstanding-transaction counter: up on issue transfer, down on response,
// never below zero; at_limit reflects the value the counter takes at this edge.
module vxe_axi_switch_us_otcnt #(
  parameter int unsigned MAX_CNT = 4,
  parameter int unsigned CNT_W   = $clog2(MAX_CNT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic at_limit
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (inc && !dec) begin
      cnt_nxt = cnt + CNT_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  // Looking at the next value counts an AR/AW completing this edge, so a
  // back-to-back pop can never push the total past MAX_CNT.
  assign at_limit = (cnt_nxt == CNT_W'(MAX_CNT));

endmodule

// File: rtl/vxe_axi_switch_us.sv
// AXI switch upstream unit: pops master request/write-data FIFOs and issues AR/AW/W
// to the BIU in order, one request in flight. Option: VXE_AXI_SWITCH_US_OTLIM_EN.
module vxe_axi_switch_us
  import vxe_axi_switch_us_pkg::*;
#(
  parameter int unsigned MAX_OUTSTND = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_m_rqa_vld,
  input  logic [RQA_W-1:0]  i_m_rqa,
  output logic              o_m_rqa_rd,
  input  logic              i_m_rqd_vld,
  input  logic [RQD_W-1:0]  i_m_rqd,
  output logic              o_m_rqd_rd,
  output logic [CID_W-1:0]  biu_arcid,
  output logic [ADDR_W-1:0] biu_araddr,
  output logic              biu_arpush,
  input  logic              biu_arready,
  output logic [CID_W-1:0]  biu_awcid,
  output logic [ADDR_W-1:0] biu_awaddr,
  output logic              biu_awpush,
  input  logic              biu_awready,
  output logic [DATA_W-1:0] biu_wdata,
  output logic [STRB_W-1:0] biu_wstrb,
  output logic              biu_wpush,
  input  logic              biu_wready,
  input  logic              i_rd_done,
  input  logic              i_wr_done
);

  us_state_t state, state_nxt;

  logic ar_xfer, aw_xfer, w_xfer;
  logic done;
  logic rnw;
  logic rd_ok, wr_ok;
  logic issue_rd, issue_wr;

  assign ar_xfer = biu_arpush && biu_arready;
  assign aw_xfer = biu_awpush && biu_awready;
  assign w_xfer  = biu_wpush  && biu_wready;
  assign rnw     = i_m_rqa[RQA_RNW];

`ifdef VXE_AXI_SWITCH_US_OTLIM_EN
  logic rd_lim, wr_lim;

  vxe_axi_switch_us_otcnt #(.MAX_CNT(MAX_OUTSTND)) u_rd_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (ar_xfer),
    .dec      (i_rd_done),
    .at_limit (rd_lim)
  );

  vxe_axi_switch_us_otcnt #(.MAX_CNT(MAX_OUTSTND)) u_wr_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (aw_xfer),
    .dec      (i_wr_done),
    .at_limit (wr_lim)
  );

  assign rd_ok = !rd_lim;
  assign wr_ok = !wr_lim;
`else
  logic unused_otlim;
  assign unused_otlim = ^{i_rd_done, i_wr_done, MAX_OUTSTND};
  assign rd_ok = 1'b1;
  assign wr_ok = 1'b1;
`endif

  // done: every push still pending transfers at this edge
  always_comb begin
    done = 1'b1;
    unique case (state)
      ST_BUSY_RD: done = ar_xfer;
      ST_BUSY_WR: done = (!biu_awpush || aw_xfer) && (!biu_wpush || w_xfer);
      default:    done = 1'b1;
    endcase
  end

  // A blocked head (write without data, or at limit) stalls everything behind it.
  assign issue_rd = !rst && done && i_m_rqa_vld &&  rnw && rd_ok;
  assign issue_wr = !rst && done && i_m_rqa_vld && !rnw && i_m_rqd_vld && wr_ok;

  assign o_m_rqa_rd = issue_rd || issue_wr;
  assign o_m_rqd_rd = issue_wr;

  always_comb begin
    state_nxt = state;
    if (issue_rd) begin
      state_nxt = ST_BUSY_RD;
    end else if (issue_wr) begin
      state_nxt = ST_BUSY_WR;
    end else if (done) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      biu_arpush <= 1'b0;
      biu_awpush <= 1'b0;
      biu_wpush  <= 1'b0;
      biu_arcid  <= '0;
      biu_araddr <= '0;
      biu_awcid  <= '0;
      biu_awaddr <= '0;
      biu_wdata  <= '0;
      biu_wstrb  <= '0;
    end else begin
      state <= state_nxt;

      if (issue_rd) begin
        biu_arpush <= 1'b1;
        biu_arcid  <= i_m_rqa[RQA_TXN_HI:RQA_TXN_LO];
        biu_araddr <= word_to_byte(i_m_rqa[RQA_WADDR_HI:RQA_WADDR_LO]);
      end else if (ar_xfer) begin
        biu_arpush <= 1'b0;
      end

      if (issue_wr) begin
        biu_awpush <= 1'b1;
        biu_wpush  <= 1'b1;
        biu_awcid  <= i_m_rqa[RQA_TXN_HI:RQA_TXN_LO];
        biu_awaddr <= word_to_byte(i_m_rqa[RQA_WADDR_HI:RQA_WADDR_LO]);
        biu_wdata  <= i_m_rqd[RQD_DATA_HI:RQD_DATA_LO];
        biu_wstrb  <= i_m_rqd[RQD_BEN_HI:RQD_BEN_LO];
      end else begin
        if (aw_xfer) begin
          biu_awpush <= 1'b0;
        end
        if (w_xfer) begin
          biu_wpush <= 1'b0;
        end
      end
    end
  end

endmodule
